// File: rtl/mfp_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mfp_irq_ctrl
//  Description : 16-channel MFP interrupt controller. It captures one-cycle
//                event pulses into IER/IPR/ISR/IMR state and arbitrates by
//                fixed priority, with channel 15 highest. It drives a
//                registered CPU request and returns an 8-bit vector on the
//                68000 interrupt-acknowledge handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module mfp_irq_ctrl #(
    parameter logic [7:0] SPURIOUS_VEC = 8'h18
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] IRQ_IN,
    input  logic [3:0]  REG_ADDR,
    input  logic        REG_WE,
    input  logic [7:0]  DAT_I,
    output logic [7:0]  DAT_O,
    input  logic        IACK,
    output logic        IRQ,
    output logic        VEC_VALID,
    output logic [7:0]  VECTOR,
    output logic        SPURIOUS
);

    // Register map
    localparam logic [3:0] c_ADDR_IERA = 4'd0;
    localparam logic [3:0] c_ADDR_IERB = 4'd1;
    localparam logic [3:0] c_ADDR_IPRA = 4'd2;
    localparam logic [3:0] c_ADDR_IPRB = 4'd3;
    localparam logic [3:0] c_ADDR_ISRA = 4'd4;
    localparam logic [3:0] c_ADDR_ISRB = 4'd5;
    localparam logic [3:0] c_ADDR_IMRA = 4'd6;
    localparam logic [3:0] c_ADDR_IMRB = 4'd7;
    localparam logic [3:0] c_ADDR_VR   = 4'd8;

    // Acknowledge handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_iack_prev;

    logic [15:0] r_ier;
    logic [15:0] r_ipr;
    logic [15:0] r_isr;
    logic [15:0] r_imr;
    logic [7:0]  r_vr;

    logic [15:0] w_elig;
    logic [15:0] w_above_isr;
    logic [15:0] w_cand;
    logic        w_win_valid;
    logic [3:0]  w_win_ch;
    logic [15:0] w_win_onehot;
    logic        w_iack_rise;
    logic        w_take;
    logic [15:0] w_ack_clr;
    logic [15:0] w_ack_set;

    logic [15:0] w_ier_nxt;
    logic [15:0] w_imr_nxt;
    logic [7:0]  w_vr_nxt;
    logic [15:0] w_ipr_keep;
    logic [15:0] w_isr_keep;
    logic [15:0] w_ipr_nxt;
    logic [15:0] w_isr_nxt;

    assign w_elig = r_ipr & r_imr;

    // Channels strictly above the highest in-service channel (all when ISR = 0)
    always_comb begin
        logic v_seen;
        v_seen      = 1'b0;
        w_above_isr = '0;
        for (int i = 15; i >= 0; i--) begin
            v_seen         = v_seen | r_isr[i];
            w_above_isr[i] = ~v_seen;
        end
    end

    assign w_cand      = w_elig & w_above_isr;
    assign w_win_valid = |w_cand;

    // Fixed-priority encoder: the last hit in ascending order is the highest
    always_comb begin
        w_win_ch = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_cand[i]) begin
                w_win_ch = 4'(i);
            end
        end
    end

    assign w_win_onehot = 16'd1 << w_win_ch;
    assign w_iack_rise  = (r_state == ST_IDLE) && IACK && !r_iack_prev;
    assign w_take       = w_iack_rise && w_win_valid;
    assign w_ack_clr    = w_take ? w_win_onehot : 16'd0;
    assign w_ack_set    = (w_take && r_vr[3]) ? w_win_onehot : 16'd0;

    // Software write decode: plain loads for IER/IMR/VR, clear-only masks for IPR/ISR
    always_comb begin
        w_ier_nxt  = r_ier;
        w_imr_nxt  = r_imr;
        w_vr_nxt   = r_vr;
        w_ipr_keep = '1;
        w_isr_keep = '1;
        if (REG_WE) begin
            case (REG_ADDR)
                c_ADDR_IERA: w_ier_nxt[15:8]  = DAT_I;
                c_ADDR_IERB: w_ier_nxt[7:0]   = DAT_I;
                c_ADDR_IPRA: w_ipr_keep[15:8] = DAT_I;
                c_ADDR_IPRB: w_ipr_keep[7:0]  = DAT_I;
                c_ADDR_ISRA: w_isr_keep[15:8] = DAT_I;
                c_ADDR_ISRB: w_isr_keep[7:0]  = DAT_I;
                c_ADDR_IMRA: w_imr_nxt[15:8]  = DAT_I;
                c_ADDR_IMRB: w_imr_nxt[7:0]   = DAT_I;
                c_ADDR_VR:   w_vr_nxt         = DAT_I;
                default:     ;
            endcase
        end
    end

    // Clears first, then new events OR in so a same-cycle event always survives;
    // likewise the acknowledge set of ISR overrides a software clear.
    assign w_ipr_nxt = ((r_ipr & w_ipr_keep & w_ier_nxt) & ~w_ack_clr) | (IRQ_IN & r_ier);
    assign w_isr_nxt = (r_isr & w_isr_keep) | w_ack_set;

    // Combinational register read-back
    always_comb begin
        DAT_O = 8'h00;
        case (REG_ADDR)
            c_ADDR_IERA: DAT_O = r_ier[15:8];
            c_ADDR_IERB: DAT_O = r_ier[7:0];
            c_ADDR_IPRA: DAT_O = r_ipr[15:8];
            c_ADDR_IPRB: DAT_O = r_ipr[7:0];
            c_ADDR_ISRA: DAT_O = r_isr[15:8];
            c_ADDR_ISRB: DAT_O = r_isr[7:0];
            c_ADDR_IMRA: DAT_O = r_imr[15:8];
            c_ADDR_IMRB: DAT_O = r_imr[7:0];
            c_ADDR_VR:   DAT_O = r_vr;
            default:     DAT_O = 8'h00;
        endcase
    end

    // Interrupt state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ier <= '0;
            r_ipr <= '0;
            r_isr <= '0;
            r_imr <= '0;
            r_vr  <= '0;
        end else begin
            r_ier <= w_ier_nxt;
            r_ipr <= w_ipr_nxt;
            r_isr <= w_isr_nxt;
            r_imr <= w_imr_nxt;
            r_vr  <= w_vr_nxt;
        end
    end

    // Acknowledge FSM with registered vector outputs; the winner is taken on the IACK rising edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_iack_prev <= 1'b1;
            VEC_VALID   <= 1'b0;
            SPURIOUS    <= 1'b0;
            VECTOR      <= 8'h00;
        end else begin
            r_iack_prev <= IACK;
            VEC_VALID   <= 1'b0;
            SPURIOUS    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_iack_rise) begin
                        r_state   <= ST_ACK;
                        VEC_VALID <= 1'b1;
                        if (w_win_valid) begin
                            VECTOR <= {r_vr[7:4], w_win_ch};
                        end else begin
                            VECTOR   <= SPURIOUS_VEC;
                            SPURIOUS <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!IACK) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // CPU request follows the arbitration result one cycle later
    always_ff @(posedge CLK) begin
        if (RST) begin
            IRQ <= 1'b0;
        end else begin
            IRQ <= w_win_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mfp_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mfp_irq_ctrl
//  Description : Self-checking bench for mfp_irq_ctrl. Directed scenarios
//                plus randomized traffic, compared each cycle against a
//                behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mfp_irq_ctrl;

    logic        CLK;
    logic        RST;
    logic [15:0] IRQ_IN;
    logic [3:0]  REG_ADDR;
    logic        REG_WE;
    logic [7:0]  DAT_I;
    logic [7:0]  DAT_O;
    logic        IACK;
    logic        IRQ;
    logic        VEC_VALID;
    logic [7:0]  VECTOR;
    logic        SPURIOUS;

    int n_checks = 0;
    int n_errors = 0;

    mfp_irq_ctrl #(.SPURIOUS_VEC(8'h18)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .IRQ_IN    (IRQ_IN),
        .REG_ADDR  (REG_ADDR),
        .REG_WE    (REG_WE),
        .DAT_I     (DAT_I),
        .DAT_O     (DAT_O),
        .IACK      (IACK),
        .IRQ       (IRQ),
        .VEC_VALID (VEC_VALID),
        .VECTOR    (VECTOR),
        .SPURIOUS  (SPURIOUS)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // Reference model state
    bit [15:0] m_ier, m_ipr, m_isr, m_imr;
    bit [7:0]  m_vr;
    bit        m_irq, m_vv, m_sp;
    bit [7:0]  m_vec;
    int        m_phase;   // 0 idle, 1 vector cycle, 2 waiting for IACK release
    bit        m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int highest(input bit [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit [7:0] mreg(input int a);
        case (a)
            0: return m_ier[15:8];
            1: return m_ier[7:0];
            2: return m_ipr[15:8];
            3: return m_ipr[7:0];
            4: return m_isr[15:8];
            5: return m_isr[7:0];
            6: return m_imr[15:8];
            7: return m_imr[7:0];
            8: return m_vr;
            default: return 8'h00;
        endcase
    endfunction

    // One clock of the behavioural model, applied with the inputs seen at that edge
    task automatic model_step(input bit [15:0] irq_in, input bit [3:0] a, input bit we,
                              input bit [7:0] d, input bit ack, input bit rst_i);
        int        hs;
        int        win;
        bit [15:0] cand;
        bit        take;
        bit [15:0] ier_old;
        bit [7:0]  vr_old;
        if (rst_i) begin
            m_ier = 0; m_ipr = 0; m_isr = 0; m_imr = 0; m_vr = 0;
            m_irq = 0; m_vv = 0; m_sp = 0; m_vec = 0;
            m_phase = 0; m_prev = 1;
            return;
        end
        ier_old = m_ier;
        vr_old  = m_vr;
        hs   = highest(m_isr);
        cand = 0;
        for (int c = 0; c < 16; c++) begin
            if (m_ipr[c] && m_imr[c] && c > hs) cand[c] = 1'b1;
        end
        win  = highest(cand);
        take = (m_phase == 0) && ack && !m_prev;
        m_vv = 0;
        m_sp = 0;
        if (we) begin
            case (a)
                4'd0: m_ier[15:8] = d;
                4'd1: m_ier[7:0]  = d;
                4'd2: m_ipr[15:8] = m_ipr[15:8] & d;
                4'd3: m_ipr[7:0]  = m_ipr[7:0] & d;
                4'd4: m_isr[15:8] = m_isr[15:8] & d;
                4'd5: m_isr[7:0]  = m_isr[7:0] & d;
                4'd6: m_imr[15:8] = d;
                4'd7: m_imr[7:0]  = d;
                4'd8: m_vr        = d;
                default: ;
            endcase
        end
        m_ipr = m_ipr & m_ier;
        if (take) begin
            m_vv = 1;
            if (win >= 0) begin
                m_vec = {vr_old[7:4], 4'(win)};
                m_ipr[win] = 1'b0;
                if (vr_old[3]) m_isr[win] = 1'b1;
            end else begin
                m_vec = 8'h18;
                m_sp  = 1;
            end
        end
        m_ipr = m_ipr | (irq_in & ier_old);
        if (m_phase == 0) begin
            if (take) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (!ack) begin
            m_phase = 0;
        end
        m_prev = ack;
        m_irq  = (win >= 0);
    endtask

    task automatic compare_all();
        check("IRQ", IRQ, m_irq);
        check("VEC_VALID", VEC_VALID, m_vv);
        check("SPURIOUS", SPURIOUS, m_sp);
        check("VECTOR", VECTOR, m_vec);
        for (int a = 0; a < 9; a++) begin
            REG_ADDR = 4'(a);
            #1;
            check($sformatf("reg%0d", a), DAT_O, mreg(a));
        end
        REG_ADDR = 4'd13;
        #1;
        check("reg13", DAT_O, 8'h00);
    endtask

    // Apply inputs for one edge, advance model, then check away from the edge
    task automatic cyc(input logic [15:0] irq_in, input logic [3:0] a, input logic we,
                       input logic [7:0] d, input logic ack, input logic rst_i);
        IRQ_IN   = irq_in;
        REG_ADDR = a;
        REG_WE   = we;
        DAT_I    = d;
        IACK     = ack;
        RST      = rst_i;
        @(posedge CLK);
        model_step(irq_in, a, we, d, ack, rst_i);
        #1;
        IRQ_IN = 16'h0;
        REG_WE = 1'b0;
        RST    = 1'b0;
        compare_all();
    endtask

    task automatic idle(input logic ack);
        cyc(16'h0, 4'd0, 1'b0, 8'h00, ack, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic ack);
        cyc(16'h0, a, 1'b1, d, ack, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        REG_ADDR = a;
        #1;
        v = DAT_O;
    endtask

    logic [7:0] rv;
    logic       r_iack;

    initial begin
        IRQ_IN = 0; REG_ADDR = 0; REG_WE = 0; DAT_I = 0; IACK = 0; RST = 1;
        cyc(16'h0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(16'h0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_irq", IRQ, 1'b0);
        check("rst_vector", VECTOR, 8'h00);

        // Basic vector
        wr(4'd8, 8'h40, 1'b0);
        wr(4'd0, 8'h20, 1'b0);
        wr(4'd6, 8'h20, 1'b0);
        cyc(16'h2000, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        rd(4'd2, rv);
        check("basic_ipra_set", rv, 8'h20);
        idle(1'b0);
        check("basic_irq_up", IRQ, 1'b1);
        idle(1'b1);
        check("basic_vv", VEC_VALID, 1'b1);
        check("basic_vector", VECTOR, 8'h4D);
        rd(4'd2, rv);
        check("basic_ipra_clr", rv, 8'h00);
        idle(1'b1);
        check("basic_irq_drop", IRQ, 1'b0);
        check("basic_vv_once", VEC_VALID, 1'b0);
        idle(1'b0);

        // Priority
        wr(4'd1, 8'h20, 1'b0);
        wr(4'd7, 8'h20, 1'b0);
        cyc(16'h2020, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        check("prio_first", VECTOR[3:0], 4'hD);
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        check("prio_second", VECTOR[3:0], 4'h5);
        idle(1'b0);

        // In-service blocking with S = 1
        wr(4'd8, 8'h48, 1'b0);
        cyc(16'h2000, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        rd(4'd4, rv);
        check("isr_set", rv, 8'h20);
        idle(1'b0);
        cyc(16'h0020, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("isr_blocks", IRQ, 1'b0);
        wr(4'd4, 8'hDF, 1'b0);
        idle(1'b0);
        check("isr_unblock", IRQ, 1'b1);
        idle(1'b1);
        check("isr_next_vec", VECTOR, 8'h45);
        idle(1'b0);

        // Mask / enable
        wr(4'd5, 8'h00, 1'b0);
        wr(4'd7, 8'h00, 1'b0);
        wr(4'd1, 8'h04, 1'b0);
        cyc(16'h0004, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1'b0);
        rd(4'd3, rv);
        check("mask_iprb", rv, 8'h04);
        check("mask_irq", IRQ, 1'b0);
        wr(4'd7, 8'h04, 1'b0);
        idle(1'b0);
        check("unmask_irq", IRQ, 1'b1);
        wr(4'd1, 8'h00, 1'b0);
        rd(4'd3, rv);
        check("ier_clr_ipr", rv, 8'h00);
        idle(1'b0);
        check("ier_clr_irq", IRQ, 1'b0);

        // Spurious and held IACK
        idle(1'b1);
        check("spur_vv", VEC_VALID, 1'b1);
        check("spur_vec", VECTOR, 8'h18);
        check("spur_flag", SPURIOUS, 1'b1);
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            check("held_iack", VEC_VALID, 1'b0);
        end
        idle(1'b0);

        // Collision then reset mid-handshake
        wr(4'd1, 8'h80, 1'b0);
        wr(4'd7, 8'h80, 1'b0);
        cyc(16'h0080, 4'd3, 1'b1, 8'h7F, 1'b0, 1'b0);
        rd(4'd3, rv);
        check("collide_iprb", rv, 8'h80);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        cyc(16'h0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("rst_mid_irq", IRQ, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("rst_no_vec", VEC_VALID, 1'b0);
        end
        idle(1'b0);
        idle(1'b1);
        check("fresh_edge_vec", VEC_VALID, 1'b1);
        idle(1'b0);

        // Randomized traffic against the model
        r_iack = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] ev;
            logic        we;
            logic [3:0]  a;
            logic [7:0]  d;
            logic        rs;
            ev = 16'($urandom) & 16'($urandom) & 16'($urandom);
            we = ($urandom_range(0, 5) == 0);
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            if (we && (a == 4'd2 || a == 4'd3 || a == 4'd4 || a == 4'd5) && $urandom_range(0, 1) == 0)
                d = d | 8'hF0 | 8'h0F ^ 8'($urandom_range(0, 15));
            if ((n % 97) == 0) begin
                we = 1'b1;
                a  = 4'($urandom_range(0, 1) == 0 ? 0 : 1) + (($urandom_range(0, 1) == 0) ? 4'd0 : 4'd6);
                d  = 8'($urandom) | 8'($urandom);
            end
            if ($urandom_range(0, 4) == 0) r_iack = ~r_iack;
            rs = ($urandom_range(0, 299) == 0);
            cyc(ev, a, we, d, r_iack, rs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
